// File: rtl/kv_table_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kv_table_pkg
//  Description : Shared codes for the suspect/arrest flow table. Status codes,
//                request/response flag bit positions and op encodings are the
//                same values the packet parser uses.
//  Revision    : 1.0 - initial release
// ============================================================================
package kv_table_pkg;

    // Flow status codes stored per entry
    localparam logic [1:0] c_STATUS_NONE     = 2'b00;
    localparam logic [1:0] c_STATUS_SUSPECT  = 2'b01;
    localparam logic [1:0] c_STATUS_ARREST   = 2'b10;
    localparam logic [1:0] c_STATUS_FILTERED = 2'b11;

    // in_flag / out_flag layout
    localparam int c_FLAG_W       = 4;
    localparam int c_FLAG_WE      = 0;  // in_flag: write-enable
    localparam int c_FLAG_STAT_LO = 1;  // in_flag/out_flag: status field low bit
    localparam int c_FLAG_STAT_HI = 2;  // in_flag/out_flag: status field high bit
    localparam int c_FLAG_RSVD    = 3;  // reserved, always 0 on out_flag
    localparam int c_FLAG_HIT     = 0;  // out_flag: hit

    // Op encodings issued by the packet parser
    localparam logic [3:0] c_OP_SUSPECT_INSERT = 4'b0011;
    localparam logic [3:0] c_OP_ARREST         = 4'b0101;

    // Timestamp width
    localparam int c_TS_W = 16;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_READ = 3'd2,
        ST_CMP  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/kv_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : kv_table_if
//  Description : Request/response bundle between the packet parser (master)
//                and the flow table (slave).
//                  in_key/in_flag/in_valid : request from the parser
//                  out_valid/out_flag      : one-cycle response
//                  busy/drop_cnt           : back-pressure status
//  Revision    : 1.0 - initial release
// ============================================================================
interface kv_table_if #(
    parameter int KEY_SIZE = 96
);
    import kv_table_pkg::*;

    logic [KEY_SIZE-1:0] in_key;
    logic [c_FLAG_W-1:0] in_flag;
    logic                in_valid;
    logic                out_valid;
    logic [c_FLAG_W-1:0] out_flag;
    logic                busy;
    logic [15:0]         drop_cnt;

    modport master (
        output in_key, in_flag, in_valid,
        input  out_valid, out_flag, busy, drop_cnt
    );

    modport slave (
        input  in_key, in_flag, in_valid,
        output out_valid, out_flag, busy, drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/kv_table_ram.sv
`default_nettype none
// ============================================================================
//  Module      : kv_table_ram
//  Description : Simple dual-port RAM, one write port, one read port with a
//                1-cycle registered read. No reset on the array or read
//                register so it maps onto block RAM.
//  Ports       : clk156, i_wr_en/i_wr_addr/i_wr_data,
//                i_rd_en/i_rd_addr, o_rd_data
//  Revision    : 1.0 - initial release
// ============================================================================
module kv_table_ram #(
    parameter int WIDTH     = 115,
    parameter int ADDR_BITS = 10
) (
    input  wire logic                 clk156,
    input  wire logic                 i_wr_en,
    input  wire logic [ADDR_BITS-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]     i_wr_data,
    input  wire logic                 i_rd_en,
    input  wire logic [ADDR_BITS-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]     o_rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk156) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk156) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/kv_table.sv
`default_nettype none
// ============================================================================
//  Module      : kv_table
//  Description : Direct-mapped flow table with per-entry timestamp ageing.
//                A request is looked up (INIT/IDLE/READ/CMP/RESP), answered
//                with {0, stored_status, hit} three cycles after in_valid,
//                and the entry is optionally inserted/upgraded/refreshed in
//                the response cycle. Requests arriving while busy are dropped.
//  Ports       : clk156  - clock
//                eth_rst - synchronous active-high reset
//                bus     - kv_table_if.slave request/response bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module kv_table
    import kv_table_pkg::*;
#(
    parameter int          KEY_SIZE = 96,
    parameter int          IDX_BITS = 10,
    parameter logic [15:0] TIMEOUT  = 16'd1000,
    parameter int          TICK_DIV = 156000
) (
    input  wire logic   clk156,
    input  wire logic   eth_rst,
    kv_table_if.slave   bus
);

    localparam int c_W      = 1 + KEY_SIZE + 2 + c_TS_W;
    localparam int c_PW     = $clog2(TICK_DIV + 1);
    localparam int c_NCHUNK = (KEY_SIZE + IDX_BITS - 1) / IDX_BITS;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);

    state_t                r_state;
    state_t                w_next;
    logic [IDX_BITS-1:0]   r_init_addr;
    logic [KEY_SIZE-1:0]   r_key;
    logic [2:0]            r_flag;
    logic [IDX_BITS-1:0]   r_idx;
    logic                  r_hit;
    logic [1:0]            r_status;
    logic                  r_out_valid;
    logic [3:0]            r_out_flag;
    logic [15:0]           r_drop_cnt;
    logic [c_TS_W-1:0]     r_now_ts;
    logic [c_PW-1:0]       r_presc;

    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [IDX_BITS-1:0]   w_ram_waddr;
    logic [c_W-1:0]        w_ram_wdata;
    logic [c_W-1:0]        w_rd_data;
    logic [IDX_BITS-1:0]   w_idx;
    logic [c_NCHUNK*IDX_BITS-1:0] w_key_pad;
    logic                  w_hit;
    logic [c_TS_W-1:0]     w_age;
    logic [1:0]            w_req;
    logic                  w_unused;

    // Reserved request bit carries no meaning for the table
    assign w_unused = bus.in_flag[c_FLAG_RSVD];

    // Index = XOR-fold of the key, zero-padded to a whole number of chunks
    assign w_key_pad = (c_NCHUNK*IDX_BITS)'(bus.in_key);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < c_NCHUNK; i++) begin
            w_idx = w_idx ^ w_key_pad[i*IDX_BITS +: IDX_BITS];
        end
    end

    // Entry fields of the word read in READ, valid during CMP
    assign w_age = r_now_ts - w_rd_data[c_TS_W-1:0];   // modulo 2^16 ageing
    assign w_hit = w_rd_data[c_W-1]
                && (w_rd_data[c_W-2 -: KEY_SIZE] == r_key)
                && (w_age <= TIMEOUT);
    assign w_req = r_flag[c_FLAG_STAT_HI:c_FLAG_STAT_LO];

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_waddr = r_idx;
        w_ram_wdata = '0;
        case (r_state)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_init_addr;
                if (r_init_addr == {IDX_BITS{1'b1}}) begin
                    w_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                w_ram_re = 1'b1;
                w_next   = ST_CMP;
            end
            ST_CMP: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                w_next = ST_IDLE;
                if (r_flag[c_FLAG_WE]) begin
                    if (!r_hit && (w_req == c_STATUS_SUSPECT)) begin
                        // Insert; a colliding occupant is simply overwritten
                        w_ram_we    = 1'b1;
                        w_ram_wdata = {1'b1, r_key, c_STATUS_SUSPECT, r_now_ts};
                    end else if (r_hit && (w_req == c_STATUS_ARREST)
                                 && (r_status == c_STATUS_SUSPECT)) begin
                        w_ram_we    = 1'b1;
                        w_ram_wdata = {1'b1, r_key, c_STATUS_ARREST, r_now_ts};
                    end else if (r_hit && (w_req == c_STATUS_SUSPECT)) begin
                        // Refresh only: stored status (possibly ARREST) is kept
                        w_ram_we    = 1'b1;
                        w_ram_wdata = {1'b1, r_key, r_status, r_now_ts};
                    end
                end
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
        // A reset landing on the write cycle must leave the RAM untouched
        if (eth_rst) begin
            w_ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_init_addr <= '0;
            r_key       <= '0;
            r_flag      <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_status    <= c_STATUS_NONE;
            r_out_valid <= 1'b0;
            r_out_flag  <= '0;
            r_drop_cnt  <= '0;
            r_now_ts    <= '0;
            r_presc     <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_addr <= r_init_addr + IDX_BITS'(1);
            end
            if ((r_state == ST_IDLE) && bus.in_valid) begin
                r_key  <= bus.in_key;
                r_flag <= bus.in_flag[2:0];
                r_idx  <= w_idx;
            end
            if (bus.in_valid && (r_state != ST_IDLE) && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_out_valid <= (r_state == ST_CMP);
            if (r_state == ST_CMP) begin
                r_hit      <= w_hit;
                r_status   <= w_hit ? w_rd_data[c_TS_W+1:c_TS_W] : c_STATUS_NONE;
                r_out_flag <= {1'b0, (w_hit ? w_rd_data[c_TS_W+1:c_TS_W] : c_STATUS_NONE), w_hit};
            end
            if (r_presc == c_PRESC_MAX) begin
                r_presc  <= '0;
                r_now_ts <= r_now_ts + 16'd1;
            end else begin
                r_presc <= r_presc + c_PW'(1);
            end
        end
    end

    kv_table_ram #(
        .WIDTH     (c_W),
        .ADDR_BITS (IDX_BITS)
    ) u_ram (
        .clk156    (clk156),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (w_ram_waddr),
        .i_wr_data (w_ram_wdata),
        .i_rd_en   (w_ram_re),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    assign bus.out_valid = r_out_valid;
    assign bus.out_flag  = r_out_flag;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
